d_cache: RTL

//  Direct-mapped, write-back, write-allocate data cache between the CPU data port and the data side of Memory.

---
 rtl/d_cache_pkg.sv | 43 ++++
 rtl/d_cache_mem_seq.sv | 33 +++
 rtl/d_cache.sv | 127 ++++++++++++
 3 files changed

// File: rtl/d_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Geometry, FSM encoding and line word helpers.
package d_cache_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int BLOCK_SIZE  = 64;
    localparam int INDEX_BITS  = 2;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int TAG_BITS    = WORD_SIZE - INDEX_BITS - 2;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        COMPARE     = 2'd0,
        WRITEBACK   = 2'd1,
        ALLOCATE    = 2'd2,
        REFILL_DONE = 2'd3
    } state_t;

    // Word 0 lives in the most significant slice of the line.
    function automatic logic [WORD_SIZE-1:0] get_word(
        input logic [BLOCK_SIZE-1:0] line,
        input logic [1:0]            off
    );
        int sh;
        sh = (3 - int'(off)) * WORD_SIZE;
        return line[sh +: WORD_SIZE];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] put_word(
        input logic [BLOCK_SIZE-1:0] line,
        input logic [1:0]            off,
        input logic [WORD_SIZE-1:0]  w
    );
        logic [BLOCK_SIZE-1:0] r;
        int sh;
        r  = line;
        sh = (3 - int'(off)) * WORD_SIZE;
        r[sh +: WORD_SIZE] = w;
        return r;
    endfunction

endpackage

// File: rtl/d_cache_mem_seq.sv
// Memory bus sequencer: latency counter, read/write strobes and done pulse.
// The counter restarts whenever the cache FSM changes state.
module d_cache_mem_seq
    import d_cache_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  state_t i_state,
    input  state_t i_next_state,
    output logic   d_readM,
    output logic   d_writeM,
    output logic   o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_busy;

    assign w_busy   = (i_state == WRITEBACK) || (i_state == ALLOCATE);
    assign d_writeM = (i_state == WRITEBACK);
    assign d_readM  = (i_state == ALLOCATE);
    assign o_done   = w_busy && (r_cnt == CNT_W'(MEM_LATENCY - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_next_state != i_state) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-back, write-allocate data cache, 4 lines of 4 words.
// Hits complete combinationally; misses write back a dirty victim then refill.
module d_cache
    import d_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [WORD_SIZE-1:0]  cpu_address,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_ready,
    output logic                  d_readM,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    inout  wire  [BLOCK_SIZE-1:0] d_data,
    output logic [WORD_SIZE-1:0]  hit_count,
    output logic [WORD_SIZE-1:0]  miss_count
);

    state_t                r_state;
    state_t                w_next_state;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [BLOCK_SIZE-1:0] r_line [LINES];
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic                  r_missed;

    logic [1:0]            w_off;
    logic [1:0]            w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_done;

    assign w_off  = cpu_address[1:0];
    assign w_idx  = cpu_address[3:2];
    assign w_tag  = cpu_address[WORD_SIZE-1:4];
    assign w_req  = cpu_read || cpu_write;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == COMPARE) && w_req && !w_hit;

    assign cpu_ready = (r_state == COMPARE) && w_req && w_hit;
    assign cpu_rdata = get_word(r_line[w_idx], w_off);
    assign d_data    = d_writeM ? r_line[w_idx] : {BLOCK_SIZE{1'bz}};

    d_cache_mem_seq u_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_state      (r_state),
        .i_next_state (w_next_state),
        .d_readM      (d_readM),
        .d_writeM     (d_writeM),
        .o_done       (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        d_address    = '0;
        unique case (r_state)
            COMPARE: begin
                if (w_miss) begin
                    w_next_state = (r_valid[w_idx] && r_dirty[w_idx])
                                 ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                d_address = {r_tag[w_idx], w_idx, 2'b00};
                if (w_done) w_next_state = ALLOCATE;
            end
            ALLOCATE: begin
                d_address = {w_tag, w_idx, 2'b00};
                if (w_done) w_next_state = REFILL_DONE;
            end
            REFILL_DONE: begin
                w_next_state = COMPARE;
            end
            default: begin
                w_next_state = COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= COMPARE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_missed   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (cpu_ready) begin
                // The final hit of a missed request is not a first-look hit.
                if (!r_missed) hit_count <= hit_count + 1'b1;
                r_missed <= 1'b0;
                if (cpu_write) r_dirty[w_idx] <= 1'b1;
            end
            if (w_miss) begin
                miss_count <= miss_count + 1'b1;
                r_missed   <= 1'b1;
            end
            if (r_state == WRITEBACK && w_done) begin
                r_dirty[w_idx] <= 1'b0;
            end
            if (r_state == ALLOCATE && w_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (cpu_ready && cpu_write) begin
            r_line[w_idx] <= put_word(r_line[w_idx], w_off, cpu_wdata);
        end
        if (r_state == ALLOCATE && w_done) begin
            r_line[w_idx] <= d_data;
            r_tag[w_idx]  <= w_tag;
        end
    end

endmodule
